xbar_out_port: RTL and testbench

Crossbar output-port controller that sits directly downstream of the `round_robin` arbiter. It presents per-input requests to the arbiter, then captures the one-hot grant. It locks the switch onto the granted input for a whole packet and moves that packet's beats through a registered valid/ready output stage. One instance exists per crossbar output.

---
 rtl/xbar_out_port.sv | 110 +++++++++++
 tb/tb_xbar_out_port.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_out_port.sv
// Crossbar output-port controller: requests arbitration, locks onto the granted
// input for one whole packet and streams its beats through a registered valid/ready stage.
module xbar_out_port #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic [N-1:0]  req_in,
  input  logic [N-1:0]  last_in,
  input  logic [N*DW-1:0] data_in,
  output logic [N-1:0]  arb_req,
  input  logic [N-1:0]  grant,
  output logic [N-1:0]  ack_out,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  output logic          last_out,
  input  logic          ready_in,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  sel, sel_next;
  logic          grant_ok;
  logic          load;
  logic [DW-1:0] sel_data;
  logic          sel_last;

  // A grant is usable only if it is one-hot and points at an input that is requesting.
  assign grant_ok = (grant != '0) &&
                    ((grant & (grant - N'(1))) == '0) &&
                    ((grant & req_in) != '0);

  assign load = (state == LOCK) && (|(req_in & sel)) && (!valid_out || ready_in);
  assign busy = (state == LOCK);

  // sel is one-hot (or zero), so an AND-OR mux is enough.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        sel_data = sel_data | data_in[i*DW +: DW];
        sel_last = sel_last | last_in[i];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next = state;
    sel_next   = sel;
    arb_req    = '0;
    ack_out    = '0;
    case (state)
      IDLE: begin
        arb_req = req_in;
        if (grant_ok) begin
          sel_next   = grant;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (load) begin
          ack_out = sel;
          if (sel_last) begin
            sel_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  // Output stage: load a new beat, drain on ready, otherwise hold.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= sel_data;
      last_out  <= sel_last;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbar_out_port.sv
// Self-checking bench for xbar_out_port: directed vector table, hand-written
// reset sequences, and randomized traffic against a packet-level reference model.
module tb_xbar_out_port;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_in;
  logic [N-1:0]  req_in, last_in, grant, arb_req, ack_out;
  logic [N*DW-1:0] data_in;
  logic          valid_out, last_out, ready_in, busy;
  logic [DW-1:0] data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xbar_out_port #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_in(rst_in), .req_in(req_in), .last_in(last_in),
    .data_in(data_in), .arb_req(arb_req), .grant(grant), .ack_out(ack_out),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
    .ready_in(ready_in), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        ready;
    logic [3:0]  e_arb;
    logic [3:0]  e_ack;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic [3:0] last, logic [31:0] data,
                              logic [3:0] grant, logic ready, logic [3:0] e_arb,
                              logic [3:0] e_ack, logic e_valid, logic [7:0] e_data,
                              logic e_last, logic e_busy);
    vec_t v;
    v.req = req; v.last = last; v.data = data; v.grant = grant; v.ready = ready;
    v.e_arb = e_arb; v.e_ack = e_ack; v.e_valid = e_valid; v.e_data = e_data;
    v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vecs[15];

  task automatic do_reset();
    rst_in = 1'b1;
    #3;
    rst_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: which input owns the port (-1 when free) and the output register.
  int         m_lock;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;

  initial begin
    rst_in = 1'b1; req_in = 4'b1011; last_in = '0; data_in = '0; grant = '0; ready_in = 1'b1;
    #2;
    check("reset_valid", valid_out, 0);
    check("reset_data",  data_out, 0);
    check("reset_last",  last_out, 0);
    check("reset_busy",  busy, 0);
    check("reset_ack",   ack_out, 0);
    check("reset_arb",   arb_req, 4'b1011);
    @(posedge clk); #1;
    rst_in = 1'b0;

    // Single packet with lock integrity and backpressure, invalid grants, back-to-back packets.
    vecs[0]  = mk(4'b0001, 4'b0000, 32'h00A0_0011, 4'b0001, 1, 4'b0001, 4'b0000, 0, 8'h00, 0, 1);
    vecs[1]  = mk(4'b1011, 4'b0000, 32'h00A1_0011, 4'b0010, 1, 4'b0000, 4'b0001, 1, 8'h11, 0, 1);
    vecs[2]  = mk(4'b1011, 4'b0000, 32'h00A2_0022, 4'b0010, 1, 4'b0000, 4'b0001, 1, 8'h22, 0, 1);
    vecs[3]  = mk(4'b1011, 4'b0001, 32'h00A3_0033, 4'b0010, 0, 4'b0000, 4'b0000, 1, 8'h22, 0, 1);
    vecs[4]  = mk(4'b1011, 4'b0001, 32'h00A4_0033, 4'b0010, 0, 4'b0000, 4'b0000, 1, 8'h22, 0, 1);
    vecs[5]  = mk(4'b1011, 4'b0001, 32'h00A5_0033, 4'b0010, 1, 4'b0000, 4'b0001, 1, 8'h33, 1, 0);
    vecs[6]  = mk(4'b0001, 4'b0000, 32'h00B0_0044, 4'b0110, 1, 4'b0001, 4'b0000, 0, 8'h33, 0, 0);
    vecs[7]  = mk(4'b0001, 4'b0000, 32'h00B1_0044, 4'b0100, 1, 4'b0001, 4'b0000, 0, 8'h33, 0, 0);
    vecs[8]  = mk(4'b1001, 4'b0000, 32'h8100_0041, 4'b0001, 1, 4'b1001, 4'b0000, 0, 8'h33, 0, 1);
    vecs[9]  = mk(4'b1001, 4'b0000, 32'h8100_0041, 4'b1000, 1, 4'b0000, 4'b0001, 1, 8'h41, 0, 1);
    vecs[10] = mk(4'b1001, 4'b0001, 32'h8100_0042, 4'b1000, 1, 4'b0000, 4'b0001, 1, 8'h42, 1, 0);
    vecs[11] = mk(4'b1001, 4'b0000, 32'h8100_0043, 4'b1000, 1, 4'b1001, 4'b0000, 0, 8'h42, 0, 1);
    vecs[12] = mk(4'b1001, 4'b0000, 32'h8100_0043, 4'b0001, 1, 4'b0000, 4'b1000, 1, 8'h81, 0, 1);
    vecs[13] = mk(4'b1001, 4'b1000, 32'h8200_0043, 4'b0001, 1, 4'b0000, 4'b1000, 1, 8'h82, 1, 0);
    vecs[14] = mk(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h82, 0, 0);

    for (int i = 0; i < 15; i++) begin
      req_in = vecs[i].req; last_in = vecs[i].last; data_in = vecs[i].data;
      grant = vecs[i].grant; ready_in = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_arb", i), arb_req, vecs[i].e_arb);
      check($sformatf("vec%0d_ack", i), ack_out, vecs[i].e_ack);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), valid_out, vecs[i].e_valid);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].e_data);
      if (vecs[i].e_valid) check($sformatf("vec%0d_last", i), last_out, vecs[i].e_last);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Mid-packet asynchronous reset truncates the packet at once.
    req_in = 4'b0001; last_in = '0; data_in = 32'h0000_0055; grant = 4'b0001; ready_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_valid_before", valid_out, 1);
    check("mid_ack_before", ack_out, 4'b0001);
    #2;
    rst_in = 1'b1;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack_out, 0);
    #1;
    rst_in = 1'b0; req_in = 4'b1011; grant = '0;
    #1;
    check("post_rst_arb", arb_req, 4'b1011);
    check("post_rst_last", last_out, 0);

    // Randomized traffic against the reference model.
    do_reset();
    m_lock = -1; m_valid = 1'b0; m_data = '0; m_last = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] r_req, r_last, r_grant, e_arb, e_ack;
      logic [31:0] r_data;
      logic r_ready, can_load;
      for (int b = 0; b < N; b++) begin
        r_req[b]  = ($urandom_range(4) != 0);
        r_last[b] = ($urandom_range(2) == 0);
      end
      r_data  = $urandom;
      r_ready = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0: r_grant = 4'b0001 << $urandom_range(3);
        1: r_grant = '0;
        default: r_grant = 4'($urandom);
      endcase
      req_in = r_req; last_in = r_last; data_in = r_data; grant = r_grant; ready_in = r_ready;

      can_load = 1'b0;
      if (m_lock < 0) begin
        e_arb = r_req;
        e_ack = '0;
      end else begin
        e_arb = '0;
        can_load = r_req[m_lock] && (!m_valid || r_ready);
        e_ack = can_load ? (4'b0001 << m_lock) : 4'b0000;
      end
      #1;
      check("rnd_arb", arb_req, e_arb);
      check("rnd_ack", ack_out, e_ack);

      if (m_lock < 0) begin
        if ($countones(r_grant) == 1 && (r_grant & r_req) != 0)
          for (int b = 0; b < N; b++) if (r_grant[b]) m_lock = b;
        if (r_ready) m_valid = 1'b0;
      end else if (can_load) begin
        m_valid = 1'b1;
        m_data  = r_data[m_lock*DW +: DW];
        m_last  = r_last[m_lock];
        if (m_last) m_lock = -1;
      end else if (r_ready) begin
        m_valid = 1'b0;
      end

      @(posedge clk); #1;
      check("rnd_valid", valid_out, m_valid);
      check("rnd_data", data_out, m_data);
      if (m_valid) check("rnd_last", last_out, m_last);
      check("rnd_busy", busy, m_lock >= 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
